// File: rtl/cv32e40p_sleep_ctrl.sv
// Sleep controller for the core clock gate.
// Drains the core after a WFI request, gates the clock once the core has been
// idle long enough, and runs a short wake sequence before handing control back.
module cv32e40p_sleep_ctrl #(
  parameter int unsigned HYST_CYCLES = 4,
  parameter int unsigned WAKE_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        sleep_req_i,
  input  logic        core_busy_i,
  input  logic        wake_i,
  output logic        clk_en_o,
  output logic        core_sleep_o,
  output logic        wake_ack_o,
  output logic [15:0] sleep_cycles_o
);

  // GATED is the only encoding with bit 2 set.
  // The clock enable and sleep flag are each a single flop bit, so they cannot glitch.
  typedef enum logic [2:0] {
    ST_RUN   = 3'b000,
    ST_DRAIN = 3'b001,
    ST_WAKE  = 3'b010,
    ST_GATED = 3'b100
  } state_t;

  localparam logic [7:0] HYST_LAST = 8'(HYST_CYCLES - 1);
  localparam logic [7:0] WAKE_LAST = 8'(WAKE_CYCLES - 1);

  state_t      r_state;
  state_t      w_stateNext;
  logic [7:0]  r_idleCnt;
  logic [7:0]  w_idleCntNext;
  logic [7:0]  r_wakeCnt;
  logic [7:0]  w_wakeCntNext;
  logic [15:0] r_sleepCycles;
  logic [15:0] w_sleepCyclesNext;

  // Next-state and counter update logic; every target is given a hold default first.
  always_comb begin
    w_stateNext       = r_state;
    w_idleCntNext     = r_idleCnt;
    w_wakeCntNext     = r_wakeCnt;
    w_sleepCyclesNext = r_sleepCycles;
    unique case (r_state)
      ST_RUN: begin
        w_idleCntNext = 8'd0;
        w_wakeCntNext = 8'd0;
        if (sleep_req_i && !wake_i) begin
          w_stateNext = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (wake_i || !sleep_req_i) begin
          w_stateNext   = ST_RUN;
          w_idleCntNext = 8'd0;
        end else if (!core_busy_i && (r_idleCnt == HYST_LAST)) begin
          w_stateNext       = ST_GATED;
          w_idleCntNext     = 8'd0;
          w_sleepCyclesNext = 16'd0;
        end else if (core_busy_i) begin
          w_idleCntNext = 8'd0;
        end else begin
          w_idleCntNext = r_idleCnt + 8'd1;
        end
      end
      ST_GATED: begin
        if (r_sleepCycles != 16'hFFFF) begin
          w_sleepCyclesNext = r_sleepCycles + 16'd1;
        end
        if (wake_i) begin
          w_stateNext   = ST_WAKE;
          w_wakeCntNext = 8'd0;
        end
      end
      ST_WAKE: begin
        if (r_wakeCnt == WAKE_LAST) begin
          w_stateNext   = ST_RUN;
          w_wakeCntNext = 8'd0;
        end else begin
          w_wakeCntNext = r_wakeCnt + 8'd1;
        end
      end
      default: begin
        w_stateNext   = ST_RUN;
        w_idleCntNext = 8'd0;
        w_wakeCntNext = 8'd0;
      end
    endcase
  end

  // State and counter registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state       <= ST_RUN;
      r_idleCnt     <= 8'd0;
      r_wakeCnt     <= 8'd0;
      r_sleepCycles <= 16'd0;
    end else begin
      r_state       <= w_stateNext;
      r_idleCnt     <= w_idleCntNext;
      r_wakeCnt     <= w_wakeCntNext;
      r_sleepCycles <= w_sleepCyclesNext;
    end
  end

  assign clk_en_o       = ~r_state[2];
  assign core_sleep_o   = r_state[2];
  assign wake_ack_o     = (r_state == ST_WAKE) && (r_wakeCnt == WAKE_LAST);
  assign sleep_cycles_o = r_sleepCycles;

endmodule
